// File: rtl/avalon_csr_responder.sv
// rtl/avalon_csr_responder.sv - Avalon-MM CSR responder with wait-state generator and pipelined reads
//
// Purpose:
//   Answers Avalon-MM commands from the peripheral clock-crossing bridge.
//   Holds a 32-word register bank, returns reads with a fixed latency and can
//   insert a programmable number of wait states on every access.
//
// Ports:
//   clk            sole clock
//   reset_n        synchronous active-low reset
//   address[6:0]   byte address, word index = address[6:2]
//   byteenable     write byte lanes
//   read / write   command strobes (both high is treated as a write)
//   writedata      write data
//   waitrequest    command not accepted this cycle
//   readdata       read response data
//   readdatavalid  one pulse per accepted read, READ_LATENCY cycles after accept
//   endofpacket    tags the response of a read from word EOP_ADDR
//   ctrl_out       CTRL register contents
//   status_in      live status, returned at word 1
//
// Register map (word index):
//   0 CTRL (RW), 1 STATUS (RO), 2 WAIT_CFG[3:0] (RW), 3 EOP_ADDR[4:0] (RW),
//   4 ACC_CNT {write_count, read_count} (any write clears), 5..31 SCRATCH (RW)

module avalon_csr_responder #(
    parameter int          READ_LATENCY = 2,
    parameter int          MAX_PENDING  = 4,
    parameter logic [31:0] RESET_CTRL   = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  address,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        endofpacket,
    output logic [31:0] ctrl_out,
    input  logic [31:0] status_in
);

    localparam int PW = $clog2(MAX_PENDING + 1);

    localparam logic [4:0] W_CTRL     = 5'd0;
    localparam logic [4:0] W_STATUS   = 5'd1;
    localparam logic [4:0] W_WAIT_CFG = 5'd2;
    localparam logic [4:0] W_EOP_ADDR = 5'd3;
    localparam logic [4:0] W_ACC_CNT  = 5'd4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t        state;
    logic [3:0]    wait_cnt;
    logic [PW-1:0] pending;

    logic [31:0]   ctrl_q;
    logic [3:0]    wait_cfg;
    logic [4:0]    eop_addr;
    logic [15:0]   write_count;
    logic [15:0]   read_count;
    logic [31:0]   scratch [32];

    logic          vld_q [READ_LATENCY];
    logic          eop_q [READ_LATENCY];
    logic [31:0]   dat_q [READ_LATENCY];

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [4:0]    word;
    logic          unused_addr_lsb;
    logic          cmd;
    logic          retiring;
    logic [PW:0]   occupancy;
    logic          room;
    logic          go;
    logic          accept;
    logic          wr_acc;
    logic          rd_acc;
    logic [31:0]   rd_word;

    assign word            = address[6:2];
    assign unused_addr_lsb = ^address[1:0];
    assign cmd             = read | write;

    // The response leaving the pipeline this cycle frees its slot in time
    // for a new read to be accepted on the same edge.
    assign retiring  = vld_q[READ_LATENCY-1];
    assign occupancy = {1'b0, pending} - (PW+1)'(retiring);
    assign room      = occupancy < (PW+1)'(MAX_PENDING);

    always_comb begin
        go = 1'b0;
        case (state)
            ST_IDLE:  go = (wait_cfg == 4'd0) && room;
            ST_STALL: go = (wait_cnt == 4'd0) && room;
            default:  go = 1'b0;
        endcase
    end

    assign accept      = reset_n & cmd & go;
    assign waitrequest = ~reset_n | (cmd & ~go);
    // Read and write together is a write; the read half is dropped.
    assign wr_acc      = accept & write;
    assign rd_acc      = accept & ~write;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        rd_word = scratch[word];
        case (word)
            W_CTRL:     rd_word = ctrl_q;
            W_STATUS:   rd_word = status_in;
            W_WAIT_CFG: rd_word = {28'd0, wait_cfg};
            W_EOP_ADDR: rd_word = {27'd0, eop_addr};
            W_ACC_CNT:  rd_word = {write_count, read_count};
            default:    rd_word = scratch[word];
        endcase
    end

    // ------------------------------------------------------------------
    // Command FSM, control registers and access counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            pending     <= '0;
            ctrl_q      <= RESET_CTRL;
            wait_cfg    <= 4'd0;
            eop_addr    <= 5'd31;
            write_count <= 16'd0;
            read_count  <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd && !go) begin
                        state <= ST_STALL;
                        // The IDLE cycle is itself the first wait state, so
                        // the counter holds the remaining ones.
                        wait_cnt <= (wait_cfg == 4'd0) ? 4'd0 : 4'(wait_cfg - 4'd1);
                    end
                end
                ST_STALL: begin
                    if (!cmd || go) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= 4'(wait_cnt - 4'd1);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (wr_acc) begin
                case (word)
                    W_CTRL: ctrl_q <= merge_bytes(ctrl_q, writedata, byteenable);
                    W_WAIT_CFG: begin
                        if (byteenable[0]) wait_cfg <= writedata[3:0];
                    end
                    W_EOP_ADDR: begin
                        if (byteenable[0]) eop_addr <= writedata[4:0];
                    end
                    default: ;
                endcase
            end

            if (wr_acc) begin
                if (word == W_ACC_CNT) begin
                    write_count <= 16'd0;
                    read_count  <= 16'd0;
                end else begin
                    write_count <= write_count + 16'd1;
                end
            end else if (rd_acc) begin
                read_count <= read_count + 16'd1;
            end

            pending <= pending + PW'(rd_acc) - PW'(retiring);
        end
    end

    // Scratch words keep their contents across reset.
    always_ff @(posedge clk) begin
        if (wr_acc && (word > W_ACC_CNT)) begin
            scratch[word] <= merge_bytes(scratch[word], writedata, byteenable);
        end
    end

    // ------------------------------------------------------------------
    // Read response pipeline: data is captured at accept and shifted out
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                eop_q[i] <= 1'b0;
                dat_q[i] <= 32'd0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            eop_q[0] <= rd_acc && (word == eop_addr);
            if (rd_acc) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                eop_q[i] <= eop_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign endofpacket   = eop_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];
    assign ctrl_out      = ctrl_q;

endmodule
